sram2_read_packer: RTL and testbench
====================================

Name: sram2_read_packer

Overview:
- Sits directly downstream of the SRAM2 read-side controller.
- Watches the controller's per-byte read strobe and captures the byte SRAM2 returns after a fixed read latency.
- Assembles NUM_BYTES bytes into one wide block and presents it to the AES datapath on a valid/ready handshake.
- Flags any byte that arrives while the packer is not filling.

Parameters:
- NUM_BYTES, 16, bytes per assembled block; power of two, 2..32.
- RD_LATENCY, 1, cycles from r_en high to valid r_data; range 1..4.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; arms the packer for a new block
- r_en  in  1  read strobe from SRAM2 controller, one byte per high cycle
- r_data  in  8  SRAM2 read data, valid RD_LATENCY cycles after r_en
- out_ready  in  1  consumer accepts block
- out_valid  out  1  assembled block available
- out_block  out  8*NUM_BYTES  assembled block
- byte_cnt  out  $clog2(NUM_BYTES)+1  bytes captured in current block
- overrun  out  1  sticky: a byte arrived outside FILL

Behaviour:
- Reset values: all outputs 0, state IDLE, strobe delay line cleared. Reset applies on the first clk edge with n_rst low, including mid-fill; a partial block is discarded.
- Capture strobe cap = r_en delayed by exactly RD_LATENCY registers. r_data is sampled on edges where cap=1.
- States:
  - IDLE: out_valid=0. On start, go to FILL and set byte_cnt=0.
  - FILL:
    - On cap, write r_data into byte slot byte_cnt and increment byte_cnt.
    - Slot k occupies out_block[8*(NUM_BYTES-k)-1 -: 8]; byte 0 is the MSB.
    - When the NUM_BYTES-th byte is captured, go to FULL on that same edge. out_valid is 1 the following cycle.
    - start in FILL restarts: byte_cnt=0. Bytes already written stay in out_block but will be overwritten. A cap on the same edge as start is written to slot 0, and byte_cnt becomes 1.
  - FULL:
    - out_valid=1; out_block and byte_cnt=NUM_BYTES held stable.
    - out_valid=1 and out_ready=1 on an edge is a transfer. After a transfer, go to IDLE and clear byte_cnt; if start is also high, go to FILL instead.
    - start without out_ready is ignored.
- Overrun: cap=1 in IDLE or FULL sets overrun and drops the byte. overrun clears only on reset or on start.
- out_valid must not drop before a transfer; out_valid never depends combinationally on out_ready.
- Latency: last r_en high at cycle t; out_valid=1 at cycle t+RD_LATENCY+1.
- byte_cnt width holds the value NUM_BYTES without wrap. No wrap-around in the slot index is possible because FILL exits at NUM_BYTES.

Optional Feature:
- Macro: SRAM2_PACK_LSB_FIRST_EN.
- Defined: slot k occupies out_block[8*k+7 -: 8], so byte 0 is the LSB, matching the little-endian key-schedule layout.
- Undefined (default): MSB-first as above. All handshake and timing behaviour is identical in both cases.

Decomposition:
- Package sram2_pkg holds:
  - typedef enum logic [1:0] pack_state_t {PK_IDLE, PK_FILL, PK_FULL};
  - localparam AES_BLOCK_BYTES = 16;
  - localparam SRAM2_DATA_W = 8.
- One sub-module, sram2_rd_strobe_delay, parameterised by RD_LATENCY:
  - shift register producing cap from r_en;
  - synchronous active-low clear on n_rst.
- The packer instantiates it once.

Test Plan:
- Reset, then start, then 16 consecutive r_en cycles with r_data = 0x00..0x0F (RD_LATENCY=1) -> out_valid rises 2 cycles after the last r_en; out_block = 0x000102030405060708090A0B0C0D0E0F; byte_cnt = 16; overrun = 0.
- Same stimulus with SRAM2_PACK_LSB_FIRST_EN defined -> out_block = 0x0F0E0D0C0B0A09080706050403020100.
- Block held with out_ready=0 for 5 cycles, then 1 -> out_valid and out_block stable for 5 cycles; state IDLE one cycle after the transfer; byte_cnt = 0.
- r_en pulse while IDLE (no start) -> overrun = 1 two cycles later; byte dropped. Next start clears overrun to 0.
- Start, 7 bytes, start again, 16 bytes 0xA0..0xAF -> out_block = 0xA0A1..AF, with no stale bytes from the aborted fill.
- n_rst low for one cycle after 9 bytes captured -> out_valid = 0, byte_cnt = 0, overrun = 0. Pending strobes in the delay line do not set overrun.
- RD_LATENCY=3 with gapped r_en (every other cycle) -> correct block; out_valid arrives 4 cycles after the last r_en.

Source files
------------

// File: rtl/sram2_pkg.sv
// sram2_pkg: shared state type and widths for the SRAM2 read-side packer.
package sram2_pkg;
    typedef enum logic [1:0] {PK_IDLE, PK_FILL, PK_FULL} pack_state_t;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int SRAM2_DATA_W = 8;
endpackage

// File: rtl/sram2_rd_strobe_delay.sv
// sram2_rd_strobe_delay: delays the SRAM2 read strobe by RD_LATENCY cycles so
// the capture strobe lines up with the returned read data.
module sram2_rd_strobe_delay
    import sram2_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic r_en,
    output logic cap
);
    logic [RD_LATENCY-1:0] sr;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr <= '0;
        end else begin
            sr[0] <= r_en;
            for (int i = 1; i < RD_LATENCY; i++) sr[i] <= sr[i-1];
        end
    end

    assign cap = sr[RD_LATENCY-1];
endmodule

// File: rtl/sram2_read_packer.sv
// sram2_read_packer: packs SRAM2 read bytes into a NUM_BYTES block for the AES datapath.
// Define SRAM2_PACK_LSB_FIRST_EN to place byte 0 in the LSB instead of the MSB.
module sram2_read_packer
    import sram2_pkg::*;
#(
    parameter int NUM_BYTES  = AES_BLOCK_BYTES,
    parameter int RD_LATENCY = 1
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                start,
    input  logic                                r_en,
    input  logic [SRAM2_DATA_W-1:0]             r_data,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [SRAM2_DATA_W*NUM_BYTES-1:0]   out_block,
    output logic [$clog2(NUM_BYTES):0]          byte_cnt,
    output logic                                overrun
);
    localparam int CW = $clog2(NUM_BYTES) + 1;
    localparam int BW = SRAM2_DATA_W * NUM_BYTES;
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_BYTES);

    pack_state_t state, state_n;
    logic [CW-1:0] cnt_n, slot;
    logic [BW-1:0] blk_n;
    logic          ovr_n, cap, wr, restart;

    function automatic int slot_lsb(input logic [CW-1:0] k);
`ifdef SRAM2_PACK_LSB_FIRST_EN
        return SRAM2_DATA_W * int'(k);
`else
        return SRAM2_DATA_W * (NUM_BYTES - 1 - int'(k));
`endif
    endfunction

    sram2_rd_strobe_delay #(.RD_LATENCY(RD_LATENCY)) u_delay (
        .clk   (clk),
        .n_rst (n_rst),
        .r_en  (r_en),
        .cap   (cap)
    );

    always_comb begin
        state_n = state;
        cnt_n   = byte_cnt;
        blk_n   = out_block;
        ovr_n   = overrun;
        slot    = byte_cnt;
        wr      = 1'b0;
        restart = 1'b0;
        case (state)
            PK_IDLE: restart = start;
            PK_FILL: begin
                restart = start;
                wr      = cap;
            end
            PK_FULL: begin
                if (out_ready) begin
                    state_n = PK_IDLE;
                    cnt_n   = '0;
                    restart = start;
                end
            end
            default: state_n = PK_IDLE;
        endcase
        if (restart) begin
            state_n = PK_FILL;
            cnt_n   = '0;
            slot    = '0;
            ovr_n   = 1'b0;
        end
        // a byte landing together with a restart goes into slot 0
        if (wr) begin
            blk_n[slot_lsb(slot) +: SRAM2_DATA_W] = r_data;
            cnt_n = slot + CW'(1);
            state_n = (cnt_n == FULL_CNT) ? PK_FULL : state_n;
        end
        ovr_n = (cap && state != PK_FILL) ? 1'b1 : ovr_n;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= PK_IDLE;
            byte_cnt  <= '0;
            out_block <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            byte_cnt  <= cnt_n;
            out_block <= blk_n;
            overrun   <= ovr_n;
        end
    end

    assign out_valid = (state == PK_FULL);
endmodule

// File: tb/tb_sram2_read_packer.sv
// tb_sram2_read_packer: scoreboard bench driving RD_LATENCY=1 and RD_LATENCY=3 packers
// with shared directed and random stimulus against a queue-based reference model.
module tb_sram2_read_packer;
    localparam int N  = 16;
    localparam int BW = 8 * N;

`ifdef SRAM2_PACK_LSB_FIRST_EN
    localparam logic [BW-1:0] EXP0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [BW-1:0] EXPA = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
`else
    localparam logic [BW-1:0] EXP0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [BW-1:0] EXPA = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
`endif

    logic clk = 1'b0;
    logic n_rst, start, r_en, out_ready;
    logic [7:0]    rd  [2];
    logic          vld [2];
    logic [BW-1:0] blk [2];
    logic [4:0]    bc  [2];
    logic          ov  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]    bhist[$];
    logic          hq [2][$];
    logic [7:0]    fq [2][$];
    logic [BW-1:0] sb [2][$];
    logic          m_fill [2];
    logic          m_full [2];
    logic          m_ovr  [2];
    logic          c, acc, outside, was_fill;

    always #5 clk = ~clk;

    sram2_read_packer #(.NUM_BYTES(N), .RD_LATENCY(1)) u1 (
        .clk(clk), .n_rst(n_rst), .start(start), .r_en(r_en), .r_data(rd[0]),
        .out_ready(out_ready), .out_valid(vld[0]), .out_block(blk[0]),
        .byte_cnt(bc[0]), .overrun(ov[0])
    );

    sram2_read_packer #(.NUM_BYTES(N), .RD_LATENCY(3)) u3 (
        .clk(clk), .n_rst(n_rst), .start(start), .r_en(r_en), .r_data(rd[1]),
        .out_ready(out_ready), .out_valid(vld[1]), .out_block(blk[1]),
        .byte_cnt(bc[1]), .overrun(ov[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [BW-1:0] pack(input logic [7:0] q[$]);
        logic [BW-1:0] b = '0;
        for (int k = 0; k < N; k++) begin
`ifdef SRAM2_PACK_LSB_FIRST_EN
            b[8*k +: 8] = q[k];
`else
            b[8*(N-1-k) +: 8] = q[k];
`endif
        end
        return b;
    endfunction

    function automatic int mcnt(input int i);
        return m_full[i] ? N : (m_fill[i] ? fq[i].size() : 0);
    endfunction

    task automatic chk(input string name, input int i, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[lat%0d] got %0h expected %0h at cycle %0d", name, lat(i), act, exp, cyc);
        end
    endtask

    // Reference model: a byte arrives L edges after its strobe and is appended to the fill queue.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            c = (hq[i].size() == lat(i)) ? hq[i][0] : 1'b0;
            if (!n_rst) begin
                hq[i].delete();
                fq[i].delete();
                sb[i].delete();
                m_fill[i] = 1'b0;
                m_full[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end else begin
                hq[i].push_back(r_en);
                if (hq[i].size() > lat(i)) void'(hq[i].pop_front());
                acc      = start && (!m_full[i] || out_ready);
                outside  = c && !m_fill[i];
                was_fill = m_fill[i];
                if (m_full[i] && out_ready) m_full[i] = 1'b0;
                if (acc) begin
                    fq[i].delete();
                    m_fill[i] = 1'b1;
                end
                if (was_fill && c) begin
                    fq[i].push_back(rd[i]);
                    if (fq[i].size() == N) begin
                        sb[i].push_back(pack(fq[i]));
                        m_fill[i] = 1'b0;
                        m_full[i] = 1'b1;
                    end
                end
                m_ovr[i] = outside ? 1'b1 : (acc ? 1'b0 : m_ovr[i]);
            end
        end
    end

    // Monitor: status against the model every cycle, block against the scoreboard while valid.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                chk("valid", i, BW'(vld[i]), BW'(m_full[i]));
                chk("byte_cnt", i, BW'(bc[i]), BW'(mcnt(i)));
                chk("overrun", i, BW'(ov[i]), BW'(m_ovr[i]));
                if (vld[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL block[lat%0d] got %0h expected no block at cycle %0d", lat(i), blk[i], cyc);
                    end else begin
                        chk("block", i, blk[i], sb[i][0]);
                        if (out_ready && n_rst) void'(sb[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic rn, input logic s, input logic e, input logic [7:0] b, input logic rdy);
        n_rst = rn;
        start = s;
        r_en = e;
        out_ready = rdy;
        bhist.push_back(b);
        if (bhist.size() > 8) void'(bhist.pop_front());
        for (int i = 0; i < 2; i++)
            rd[i] = (bhist.size() > lat(i)) ? bhist[bhist.size()-1-lat(i)] : 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 8'($urandom), rdy);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_valid", 0, BW'(vld[0]), '0);
        chk("rst_cnt", 0, BW'(bc[0]), '0);
        chk("rst_ovr", 0, BW'(ov[0]), '0);
        chk("rst_block", 0, blk[0], '0);

        // contiguous 0x00..0x0F, latency, hold with out_ready low
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b1, 8'(k), 1'b0);
        chk("lat1_early", 0, BW'(vld[0]), '0);
        idle(1, 1'b0);
        chk("lat1_valid", 0, BW'(vld[0]), BW'(1));
        chk("lat3_early", 1, BW'(vld[1]), '0);
        idle(1, 1'b0);
        chk("lat3_early", 1, BW'(vld[1]), '0);
        idle(1, 1'b0);
        chk("lat3_valid", 1, BW'(vld[1]), BW'(1));
        chk("blk_seq", 0, blk[0], EXP0);
        chk("blk_seq", 1, blk[1], EXP0);
        chk("full_cnt", 0, BW'(bc[0]), BW'(N));
        chk("no_ovr", 0, BW'(ov[0]), '0);
        idle(3, 1'b0);
        chk("blk_hold", 0, blk[0], EXP0);
        idle(1, 1'b1);
        chk("post_xfer_valid", 0, BW'(vld[0]), '0);
        chk("post_xfer_cnt", 0, BW'(bc[0]), '0);
        chk("post_xfer_valid", 1, BW'(vld[1]), '0);

        // strobe while idle sets overrun; next start clears it
        step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("ovr_early", 0, BW'(ov[0]), '0);
        idle(1, 1'b0);
        chk("ovr_set", 0, BW'(ov[0]), BW'(1));
        idle(2, 1'b0);
        chk("ovr_set", 1, BW'(ov[1]), BW'(1));
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("ovr_clr", 0, BW'(ov[0]), '0);
        chk("ovr_clr", 1, BW'(ov[1]), '0);

        // aborted fill, then restart with 0xA0..0xAF
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b1, 8'(8'hA0 + k), 1'b0);
        idle(3, 1'b0);
        chk("blk_restart", 0, blk[0], EXPA);
        chk("blk_restart", 1, blk[1], EXPA);
        idle(1, 1'b1);

        // reset mid-fill with strobes still in flight
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0);
        chk("midrst_cnt", 0, BW'(bc[0]), '0);
        chk("midrst_valid", 1, BW'(vld[1]), '0);
        idle(4, 1'b0);
        chk("midrst_ovr", 0, BW'(ov[0]), '0);
        chk("midrst_ovr", 1, BW'(ov[1]), '0);
        chk("midrst_cnt", 1, BW'(bc[1]), '0);

        // gapped strobes
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
            if (k < N - 1) idle(1, 1'b0);
        end
        idle(2, 1'b0);
        chk("gap_lat3_early", 1, BW'(vld[1]), '0);
        idle(1, 1'b0);
        chk("gap_lat3_valid", 1, BW'(vld[1]), BW'(1));
        idle(1, 1'b1);

        // random traffic
        for (int k = 0; k < 3000; k++)
            step(($urandom % 300) != 0, ($urandom % 60) == 0, $urandom % 2, 8'($urandom), ($urandom % 3) != 0);

        idle(40, 1'b1);
        for (int i = 0; i < 2; i++) chk("sb_drain", i, BW'(sb[i].size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
